opgen_stage: RTL and testbench

Registered, parametrised op-generation stage for the multi-issue ID path. Decodes a fetch packet of `WAYS` MIPS32 instructions per cycle into per-way `OPGEN_*` operation codes, a function-unit class and a reserved-instruction flag, then buffers decoded packets in a `DEPTH`-entry FIFO. It sits between the fetch queue and rename/dispatch, with valid/ready handshakes on both sides.

---
 rtl/opgen_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_opgen_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/opgen_stage.sv
// Multi-issue op-generation stage: per-way MIPS32 decode into a DEPTH-entry packet FIFO.
// Define OPGEN_SPECIAL2_EN to build SPECIAL2 (MADD/MUL/CLZ...) decode; otherwise SPECIAL2 is reserved.
package opgen_pkg;
   typedef enum logic [5:0] {
      OP_NOP   = 6'd0,  OP_ADD   = 6'd1,  OP_SUB   = 6'd2,  OP_SLT   = 6'd3,
      OP_SLTU  = 6'd4,  OP_AND   = 6'd5,  OP_OR    = 6'd6,  OP_NOR   = 6'd7,
      OP_XOR   = 6'd8,  OP_SLL   = 6'd9,  OP_SRA   = 6'd10, OP_SRL   = 6'd11,
      OP_MOVZ  = 6'd12, OP_MOVN  = 6'd13, OP_DIV   = 6'd14, OP_DIVU  = 6'd15,
      OP_MULT  = 6'd16, OP_MULTU = 6'd17, OP_JR    = 6'd18, OP_MADD  = 6'd19,
      OP_MADDU = 6'd20, OP_MSUB  = 6'd21, OP_MSUBU = 6'd22, OP_MUL   = 6'd23,
      OP_CLZ   = 6'd24, OP_CLO   = 6'd25, OP_BLTZ  = 6'd26, OP_BGEZ  = 6'd27,
      OP_BEQ   = 6'd28, OP_BNE   = 6'd29, OP_BGTZ  = 6'd30, OP_BLEZ  = 6'd31,
      OP_J     = 6'd32, OP_MEM   = 6'd33
   } opgen_e;

   typedef enum logic [2:0] {
      UNIT_NONE = 3'd0, UNIT_ALU = 3'd1, UNIT_MDU = 3'd2,
      UNIT_BRU  = 3'd3, UNIT_LSU = 3'd4, UNIT_CP0 = 3'd5
   } unit_e;

   typedef struct packed {
      opgen_e op;
      unit_e  unit;
      logic   ri;
   } dec_t;
endpackage

module opgen_stage
   import opgen_pkg::*;
#(
   parameter int unsigned WAYS        = 2,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned OPGEN_WIDTH = 6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [32*WAYS-1:0]          in_inst,
   input  logic [WAYS-1:0]             in_mask,
   input  logic [31:0]                 in_pc,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OPGEN_WIDTH*WAYS-1:0] out_opgen,
   output logic [3*WAYS-1:0]           out_unit,
   output logic [WAYS-1:0]             out_ri,
   output logic [WAYS-1:0]             out_mask,
   output logic [31:0]                 out_pc
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [OPGEN_WIDTH*WAYS-1:0] opgen;
      logic [3*WAYS-1:0]           unit;
      logic [WAYS-1:0]             ri;
      logic [WAYS-1:0]             mask;
      logic [31:0]                 pc;
   } pkt_t;

   function automatic dec_t mk(input opgen_e op, input unit_e unit, input logic ri);
      dec_t d;
      d.op   = op;
      d.unit = unit;
      d.ri   = ri;
      return d;
   endfunction

   function automatic dec_t decode(input logic [31:0] inst);
      logic [5:0] opc;
      logic [5:0] fn;
      logic [4:0] rs;
      logic [4:0] rt;
      dec_t       d;
      opc = inst[31:26];
      rs  = inst[25:21];
      rt  = inst[20:16];
      fn  = inst[5:0];
      d   = mk(OP_NOP, UNIT_NONE, 1'b1);
      case (opc)
         6'h00: begin
            case (fn)
               6'h20, 6'h21: d = mk(OP_ADD,   UNIT_ALU,  1'b0);
               6'h22, 6'h23: d = mk(OP_SUB,   UNIT_ALU,  1'b0);
               6'h2A:        d = mk(OP_SLT,   UNIT_ALU,  1'b0);
               6'h2B:        d = mk(OP_SLTU,  UNIT_ALU,  1'b0);
               6'h24:        d = mk(OP_AND,   UNIT_ALU,  1'b0);
               6'h25:        d = mk(OP_OR,    UNIT_ALU,  1'b0);
               6'h27:        d = mk(OP_NOR,   UNIT_ALU,  1'b0);
               6'h26:        d = mk(OP_XOR,   UNIT_ALU,  1'b0);
               6'h00, 6'h04: d = mk(OP_SLL,   UNIT_ALU,  1'b0);
               6'h03, 6'h07: d = mk(OP_SRA,   UNIT_ALU,  1'b0);
               6'h02, 6'h06: d = mk(OP_SRL,   UNIT_ALU,  1'b0);
               6'h0A:        d = mk(OP_MOVZ,  UNIT_ALU,  1'b0);
               6'h0B:        d = mk(OP_MOVN,  UNIT_ALU,  1'b0);
               6'h1A:        d = mk(OP_DIV,   UNIT_MDU,  1'b0);
               6'h1B:        d = mk(OP_DIVU,  UNIT_MDU,  1'b0);
               6'h18:        d = mk(OP_MULT,  UNIT_MDU,  1'b0);
               6'h19:        d = mk(OP_MULTU, UNIT_MDU,  1'b0);
               // HI/LO moves are plain register copies executed in the MDU
               6'h10, 6'h11, 6'h12, 6'h13: d = mk(OP_OR, UNIT_MDU, 1'b0);
               6'h08, 6'h09: d = mk(OP_JR,    UNIT_BRU,  1'b0);
               6'h0C, 6'h0D: d = mk(OP_NOP,   UNIT_NONE, 1'b0);
               default: ;
            endcase
         end
         6'h01: begin
            case (rt)
               5'h00, 5'h10: d = mk(OP_BLTZ, UNIT_BRU, 1'b0);
               5'h01, 5'h11: d = mk(OP_BGEZ, UNIT_BRU, 1'b0);
               default: ;
            endcase
         end
         6'h02, 6'h03: d = mk(OP_J,    UNIT_BRU, 1'b0);
         6'h04:        d = mk(OP_BEQ,  UNIT_BRU, 1'b0);
         6'h05:        d = mk(OP_BNE,  UNIT_BRU, 1'b0);
         6'h06:        d = mk(OP_BLEZ, UNIT_BRU, 1'b0);
         6'h07:        d = mk(OP_BGTZ, UNIT_BRU, 1'b0);
         6'h08, 6'h09: d = mk(OP_ADD,  UNIT_ALU, 1'b0);
         6'h0A:        d = mk(OP_SLT,  UNIT_ALU, 1'b0);
         6'h0B:        d = mk(OP_SLTU, UNIT_ALU, 1'b0);
         6'h0C:        d = mk(OP_AND,  UNIT_ALU, 1'b0);
         6'h0D, 6'h0F: d = mk(OP_OR,   UNIT_ALU, 1'b0);
         6'h0E:        d = mk(OP_XOR,  UNIT_ALU, 1'b0);
         6'h10: begin
            if (rs == 5'h00 || rs == 5'h04)
               d = mk(OP_OR, UNIT_CP0, 1'b0);
            else if (rs[4] && fn == 6'h18)
               d = mk(OP_NOP, UNIT_CP0, 1'b0);
         end
`ifdef OPGEN_SPECIAL2_EN
         6'h1C: begin
            case (fn)
               6'h00: d = mk(OP_MADD,  UNIT_MDU, 1'b0);
               6'h01: d = mk(OP_MADDU, UNIT_MDU, 1'b0);
               6'h02: d = mk(OP_MUL,   UNIT_MDU, 1'b0);
               6'h04: d = mk(OP_MSUB,  UNIT_MDU, 1'b0);
               6'h05: d = mk(OP_MSUBU, UNIT_MDU, 1'b0);
               6'h20: d = mk(OP_CLZ,   UNIT_ALU, 1'b0);
               6'h21: d = mk(OP_CLO,   UNIT_ALU, 1'b0);
               default: ;
            endcase
         end
`endif
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B:
            d = mk(OP_MEM, UNIT_LSU, 1'b0);
         default: ;
      endcase
      return d;
   endfunction

   pkt_t          push_pkt;
   pkt_t          mem_q [DEPTH];
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic          push, pop;

   always_comb begin
      push_pkt      = '0;
      push_pkt.mask = in_mask;
      push_pkt.pc   = in_pc;
      for (int unsigned w = 0; w < WAYS; w++) begin
         dec_t dec;
         dec = in_mask[w] ? decode(in_inst[32*w +: 32]) : mk(OP_NOP, UNIT_NONE, 1'b0);
         push_pkt.opgen[OPGEN_WIDTH*w +: OPGEN_WIDTH] = OPGEN_WIDTH'(dec.op);
         push_pkt.unit[3*w +: 3]                      = dec.unit;
         push_pkt.ri[w]                               = dec.ri;
      end
   end

   assign in_ready  = (count_q != FULL);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         count_d = '0;
         head_d  = '0;
         tail_d  = '0;
      end else begin
         if (push && !pop)
            count_d = count_q + 1'b1;
         else if (pop && !push)
            count_d = count_q - 1'b1;
         if (push)
            tail_d = tail_q + 1'b1;
         if (pop)
            head_d = head_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem_q[tail_q] <= push_pkt;
   end

   // Outputs gated by the live count so an async reset blanks them at once (OP_NOP is all-zero).
   always_comb begin
      out_opgen = '0;
      out_unit  = '0;
      out_ri    = '0;
      out_mask  = '0;
      out_pc    = '0;
      if (out_valid) begin
         out_opgen = mem_q[head_q].opgen;
         out_unit  = mem_q[head_q].unit;
         out_ri    = mem_q[head_q].ri;
         out_mask  = mem_q[head_q].mask;
         out_pc    = mem_q[head_q].pc;
      end
   end

endmodule

// File: tb/tb_opgen_stage.sv
// Scoreboard bench for opgen_stage (WAYS=2, DEPTH=4); honours OPGEN_SPECIAL2_EN for the MUL vector.
module tb_opgen_stage;

   localparam logic [5:0] C_NOP = 6'd0,  C_ADD  = 6'd1,  C_OR  = 6'd6,  C_SRA = 6'd10;
   localparam logic [5:0] C_JR  = 6'd18, C_MUL  = 6'd23, C_BGEZ = 6'd27, C_BEQ = 6'd28;
   localparam logic [5:0] C_MEM = 6'd33;
   localparam logic [2:0] U_NONE = 3'd0, U_ALU = 3'd1, U_MDU = 3'd2, U_BRU = 3'd3;
   localparam logic [2:0] U_LSU  = 3'd4, U_CP0 = 3'd5;

   typedef struct packed {
      logic [11:0] op;
      logic [5:0]  unit;
      logic [1:0]  ri;
      logic [1:0]  mask;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_inst = '0;
   logic [1:0]  in_mask = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] out_opgen;
   logic [5:0]  out_unit;
   logic [1:0]  out_ri;
   logic [1:0]  out_mask;
   logic [31:0] out_pc;

   exp_t exp_q[$];
   exp_t drv_exp;
   int   vectors = 0;
   int   miscompares = 0;

   opgen_stage #(.WAYS(2), .DEPTH(4), .OPGEN_WIDTH(6)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_mask(in_mask), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_opgen(out_opgen),
      .out_unit(out_unit), .out_ri(out_ri), .out_mask(out_mask), .out_pc(out_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor pops before the pusher records, both ahead of the next rising edge.
   always @(negedge clk) begin
      if (!rst || flush) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            exp_t act, e;
            act = '{op:out_opgen, unit:out_unit, ri:out_ri, mask:out_mask, pc:out_pc};
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL pkt_unexpected: got %h, want none", act);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  miscompares++;
                  $display("FAIL pkt pc=%h: got op=%h unit=%h ri=%b mask=%b pc=%h, want op=%h unit=%h ri=%b mask=%b pc=%h",
                           e.pc, act.op, act.unit, act.ri, act.mask, act.pc,
                           e.op, e.unit, e.ri, e.mask, e.pc);
               end
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(drv_exp);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, want);
      end
   endtask

   task automatic send(input logic [31:0] i1, input logic [31:0] i0, input logic [1:0] m,
                       input logic [31:0] pc, input logic [5:0] o1, input logic [5:0] o0,
                       input logic [2:0] u1, input logic [2:0] u0, input logic [1:0] ri);
      in_inst  = {i1, i0};
      in_mask  = m;
      in_pc    = pc;
      in_valid = 1'b1;
      drv_exp  = '{op:{o1, o0}, unit:{u1, u0}, ri:ri, mask:m, pc:pc};
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_simple(input logic [31:0] pc);
      send(32'h8C430004, 32'h00221821, 2'b11, pc, C_MEM, C_ADD, U_LSU, U_ALU, 2'b00);
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !out_valid) break;
      end
      chk({name, "_drained_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_drained_queue"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_in_ready"},  64'(in_ready),  64'd1);
      chk({name, "_opgen"},     64'(out_opgen), 64'd0);
      chk({name, "_unit"},      64'(out_unit),  64'd0);
      chk({name, "_ri"},        64'(out_ri),    64'd0);
      chk({name, "_mask"},      64'(out_mask),  64'd0);
      chk({name, "_pc"},        64'(out_pc),    64'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;

      // decode vectors, one per cycle with a ready consumer
      out_ready = 1'b1;
      send(32'h8C430004, 32'h00221821, 2'b11, 32'h0000_1000, C_MEM, C_ADD, U_LSU, U_ALU, 2'b00);
      chk("latency_out_valid", 64'(out_valid), 64'd1);
`ifdef OPGEN_SPECIAL2_EN
      send(32'h00221821, 32'h70221002, 2'b11, 32'h0000_1008, C_ADD, C_MUL, U_ALU, U_MDU, 2'b00);
`else
      send(32'h00221821, 32'h70221002, 2'b11, 32'h0000_1008, C_ADD, C_NOP, U_ALU, U_NONE, 2'b01);
`endif
      send(32'h00221821, 32'hFC000000, 2'b01, 32'h0000_1010, C_NOP, C_NOP, U_NONE, U_NONE, 2'b01);
      send(32'h10220003, 32'h03E00008, 2'b11, 32'h0000_1018, C_BEQ, C_JR, U_BRU, U_BRU, 2'b00);
      send(32'h40026000, 32'h42000018, 2'b11, 32'h0000_1020, C_OR, C_NOP, U_CP0, U_CP0, 2'b00);
      send(32'h04310002, 32'h0000000C, 2'b11, 32'h0000_1028, C_BGEZ, C_NOP, U_BRU, U_NONE, 2'b00);
      send(32'h00021843, 32'h3C011234, 2'b11, 32'h0000_1030, C_SRA, C_OR, U_ALU, U_ALU, 2'b00);
      send(32'h0000003F, 32'h00001812, 2'b11, 32'h0000_1038, C_NOP, C_OR, U_NONE, U_MDU, 2'b10);
      drain("decode");

      // fill to DEPTH with a stalled consumer
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("fill_in_ready", 64'(in_ready), 64'd1);
         send_simple(32'h0000_2000 + 32'(k));
      end
      chk("full_in_ready", 64'(in_ready), 64'd0);
      send_simple(32'h0000_20FF);
      out_ready = 1'b1;
      #1;
      chk("full_no_comb_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("after_pop_in_ready", 64'(in_ready), 64'd1);
      drain("fill");

      // steady state at two entries
      out_ready = 1'b0;
      send_simple(32'h0000_3000);
      send_simple(32'h0000_3001);
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         send_simple(32'h0000_3100 + 32'(k));
         chk("stream_count", 64'(dut.count_q), 64'd2);
      end
      drain("stream");

      // flush with three entries and a same-cycle push
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) send_simple(32'h0000_4000 + 32'(k));
      in_inst   = {32'h8C430004, 32'h00221821};
      in_mask   = 2'b11;
      in_pc     = 32'h0000_40FF;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_count", 64'(dut.count_q), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      send_simple(32'h0000_4100);
      drain("post_flush");

      // asynchronous reset mid-cycle
      out_ready = 1'b0;
      send_simple(32'h0000_5000);
      send_simple(32'h0000_5001);
      #2;
      rst = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      send_simple(32'h0000_5100);
      drain("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
